// File: rtl/traffic_phase_controller.sv
// Actuated intersection controller: main road rests in green, side approaches are served
// round-robin on demand, with a maintenance flash mode that overrides the phase timers.
module traffic_phase_controller #(
  parameter int N_APPROACH   = 4,
  parameter int GREEN_MIN    = 4,
  parameter int GREEN_MAX    = 10,
  parameter int YELLOW_TIME  = 2,
  parameter int ALL_RED_TIME = 1,
  parameter int FLASH_HALF   = 3,
  parameter int CNT_W        = 8,
  localparam int PW = (N_APPROACH > 2) ? $clog2(N_APPROACH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_APPROACH-1:0]   sensor,
  input  logic                    flash,
  output logic [2*N_APPROACH-1:0] light,
  output logic [PW-1:0]           phase,
  output logic                    phase_start
);

  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALL_RED, S_FLASH} state_t;

  localparam logic [1:0] LT_RED    = 2'b00;
  localparam logic [1:0] LT_YELLOW = 2'b01;
  localparam logic [1:0] LT_GREEN  = 2'b10;
  localparam logic [1:0] LT_OFF    = 2'b11;

  localparam logic [CNT_W-1:0] GMIN_M1  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_M1  = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_M1   = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] AR_M1    = CNT_W'(ALL_RED_TIME - 1);
  localparam logic [CNT_W-1:0] FLASH_M1 = CNT_W'(FLASH_HALF - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [PW-1:0]    phase_n;
  logic             flash_on, flash_on_n;
  logic             from_flash, from_flash_n;
  logic             start_n;
  logic             side_req;
  logic             green_done;

  // First requesting approach after cur, wrapping; approach 0 when nobody else asks.
  function automatic logic [PW-1:0] rr_pick(input logic [PW-1:0] cur,
                                            input logic [N_APPROACH-1:0] req);
    logic [PW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k < N_APPROACH; k++) begin
      idx = (int'(cur) + k) % N_APPROACH;
      if (!found && req[idx]) begin
        pick  = PW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [2*N_APPROACH-1:0] light_of(input state_t s,
                                                       input logic [PW-1:0] p,
                                                       input logic fon);
    logic [2*N_APPROACH-1:0] l;
    l = '0;
    for (int i = 0; i < N_APPROACH; i++) begin
      case (s)
        S_GREEN:  l[2*i +: 2] = (PW'(i) == p) ? LT_GREEN  : LT_RED;
        S_YELLOW: l[2*i +: 2] = (PW'(i) == p) ? LT_YELLOW : LT_RED;
        S_FLASH:  l[2*i +: 2] = !fon ? LT_OFF : ((i == 0) ? LT_YELLOW : LT_RED);
        default:  l[2*i +: 2] = LT_RED;
      endcase
    end
    return l;
  endfunction

  assign side_req   = |sensor[N_APPROACH-1:1];
  // Main road has no max: it only yields once someone else is waiting.
  assign green_done = (phase == '0)
                    ? (timer >= GMIN_M1 && side_req)
                    : ((timer >= GMIN_M1 && !sensor[phase]) || timer >= GMAX_M1);

  always_comb begin
    state_n      = state;
    phase_n      = phase;
    timer_n      = (timer == '1) ? timer : timer + 1'b1;
    flash_on_n   = flash_on;
    from_flash_n = from_flash;
    start_n      = 1'b0;
    if (flash) begin
      if (state != S_FLASH) begin
        state_n    = S_FLASH;
        timer_n    = '0;
        flash_on_n = 1'b1;
      end else if (timer >= FLASH_M1) begin
        timer_n    = '0;
        flash_on_n = !flash_on;
      end
    end else begin
      case (state)
        S_GREEN:
          if (green_done) begin
            state_n = S_YELLOW;
            timer_n = '0;
          end
        S_YELLOW:
          if (timer >= YEL_M1) begin
            state_n = S_ALL_RED;
            timer_n = '0;
          end
        S_ALL_RED:
          if (timer >= AR_M1) begin
            state_n      = S_GREEN;
            timer_n      = '0;
            phase_n      = from_flash ? '0 : rr_pick(phase, sensor);
            from_flash_n = 1'b0;
            start_n      = 1'b1;
          end
        default: begin
          state_n      = S_ALL_RED;
          timer_n      = '0;
          from_flash_n = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_GREEN;
      timer       <= '0;
      phase       <= '0;
      flash_on    <= 1'b0;
      from_flash  <= 1'b0;
      phase_start <= 1'b0;
      light       <= light_of(S_GREEN, '0, 1'b0);
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      phase       <= phase_n;
      flash_on    <= flash_on_n;
      from_flash  <= from_flash_n;
      phase_start <= start_n;
      light       <= light_of(state_n, phase_n, flash_on_n);
    end
  end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed-vector bench: stimulus pushes hand-computed expectations tagged with the cycle
// they apply to; an independent monitor pops and compares at each falling edge.
module tb_traffic_phase_controller;

  localparam int N = 4;
  localparam int K_G = 0, K_Y = 1, K_AR = 2, K_FON = 3, K_FOFF = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           flash;
  logic [N-1:0]   sensor;
  logic [2*N-1:0] light;
  logic [1:0]     phase;
  logic           phase_start;

  traffic_phase_controller #(
    .N_APPROACH(4), .GREEN_MIN(4), .GREEN_MAX(10), .YELLOW_TIME(2),
    .ALL_RED_TIME(1), .FLASH_HALF(3), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .sensor(sensor), .flash(flash),
    .light(light), .phase(phase), .phase_start(phase_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             cyc;
    logic [2*N-1:0] light;
    logic [1:0]     phase;
    logic           ps;
    string          tag;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   cyc = 0;
  int   applied = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*N-1:0] exp_light(input int kind, input int ph);
    logic [2*N-1:0] l;
    l = '0;
    case (kind)
      K_G:     l[2*ph +: 2] = 2'b10;
      K_Y:     l[2*ph +: 2] = 2'b01;
      K_FON:   l = 8'b00_00_00_01;
      K_FOFF:  l = 8'b11_11_11_11;
      default: l = '0;
    endcase
    return l;
  endfunction

  // Monitor
  initial forever begin
    @(negedge clk);
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m = q.pop_front();
      applied++;
      if (light !== m.light || phase !== m.phase || phase_start !== m.ps) begin
        errors++;
        $display("FAIL %s cyc=%0d: got light=%b phase=%0d start=%b, want light=%b phase=%0d start=%b",
                 m.tag, cyc, light, phase, phase_start, m.light, m.phase, m.ps);
      end
    end
  end

  task automatic vec(input string tag, input logic [3:0] s, input logic f, input logic r,
                     input int kind, input int ph, input logic ps);
    exp_t e;
    sensor = s;
    flash  = f;
    rst    = r;
    e.cyc   = cyc + 1;
    e.light = exp_light(kind, ph);
    e.phase = 2'(ph);
    e.ps    = ps;
    e.tag   = tag;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic rep(input int n, input string tag, input logic [3:0] s, input logic f,
                     input logic r, input int kind, input int ph, input logic ps);
    for (int i = 0; i < n; i++) vec(tag, s, f, r, kind, ph, ps);
  endtask

  initial begin
    sensor = '0;
    flash  = 1'b1;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    // reset overrides flash
    rep(2, "reset_over_flash", 4'b0000, 1'b1, 1'b1, K_G, 0, 1'b0);
    rep(50, "idle_main", 4'b0000, 1'b0, 1'b0, K_G, 0, 1'b0);

    // side service from reset: main 4, yellow 2, all-red 1, side 10 (max), back to 0
    vec("svc_reset", 4'b0000, 1'b0, 1'b1, K_G, 0, 1'b0);
    rep(3, "svc_main_min", 4'b0100, 1'b0, 1'b0, K_G, 0, 1'b0);
    rep(2, "svc_main_yel", 4'b0100, 1'b0, 1'b0, K_Y, 0, 1'b0);
    vec("svc_main_ar", 4'b0100, 1'b0, 1'b0, K_AR, 0, 1'b0);
    vec("svc_side_start", 4'b0100, 1'b0, 1'b0, K_G, 2, 1'b1);
    rep(9, "svc_side_green", 4'b0100, 1'b0, 1'b0, K_G, 2, 1'b0);
    rep(2, "svc_side_yel_max", 4'b0100, 1'b0, 1'b0, K_Y, 2, 1'b0);
    vec("svc_side_ar", 4'b0100, 1'b0, 1'b0, K_AR, 2, 1'b0);
    vec("svc_back_main", 4'b0100, 1'b0, 1'b0, K_G, 0, 1'b1);
    rep(3, "svc_main_hold", 4'b0000, 1'b0, 1'b0, K_G, 0, 1'b0);

    // round robin: 1 -> 3 -> 0 with sensor 1011
    vec("rr_leave_main", 4'b0010, 1'b0, 1'b0, K_Y, 0, 1'b0);
    vec("rr_yel0", 4'b0010, 1'b0, 1'b0, K_Y, 0, 1'b0);
    vec("rr_ar0", 4'b0010, 1'b0, 1'b0, K_AR, 0, 1'b0);
    vec("rr_start1", 4'b0010, 1'b0, 1'b0, K_G, 1, 1'b1);
    rep(9, "rr_green1", 4'b1011, 1'b0, 1'b0, K_G, 1, 1'b0);
    rep(2, "rr_yel1", 4'b1011, 1'b0, 1'b0, K_Y, 1, 1'b0);
    vec("rr_ar1", 4'b1011, 1'b0, 1'b0, K_AR, 1, 1'b0);
    vec("rr_start3", 4'b1011, 1'b0, 1'b0, K_G, 3, 1'b1);
    rep(9, "rr_green3", 4'b1011, 1'b0, 1'b0, K_G, 3, 1'b0);
    rep(2, "rr_yel3", 4'b1011, 1'b0, 1'b0, K_Y, 3, 1'b0);
    vec("rr_ar3", 4'b1011, 1'b0, 1'b0, K_AR, 3, 1'b0);
    vec("rr_start0", 4'b1011, 1'b0, 1'b0, K_G, 0, 1'b1);
    rep(3, "rr_green0", 4'b1011, 1'b0, 1'b0, K_G, 0, 1'b0);
    rep(2, "rr_yel0b", 4'b1011, 1'b0, 1'b0, K_Y, 0, 1'b0);
    vec("rr_ar0b", 4'b1011, 1'b0, 1'b0, K_AR, 0, 1'b0);
    vec("rr_start1b", 4'b1011, 1'b0, 1'b0, K_G, 1, 1'b1);
    rep(3, "rr_release1", 4'b0000, 1'b0, 1'b0, K_G, 1, 1'b0);
    rep(2, "rr_yel1b", 4'b0000, 1'b0, 1'b0, K_Y, 1, 1'b0);
    vec("rr_ar1b", 4'b0000, 1'b0, 1'b0, K_AR, 1, 1'b0);
    vec("rr_idle_to0", 4'b0000, 1'b0, 1'b0, K_G, 0, 1'b1);

    // early side release: sensor[2] drops at green cycle 2, green lasts GREEN_MIN
    rep(3, "er_main", 4'b0100, 1'b0, 1'b0, K_G, 0, 1'b0);
    rep(2, "er_yel0", 4'b0100, 1'b0, 1'b0, K_Y, 0, 1'b0);
    vec("er_ar0", 4'b0100, 1'b0, 1'b0, K_AR, 0, 1'b0);
    vec("er_start2", 4'b0100, 1'b0, 1'b0, K_G, 2, 1'b1);
    vec("er_green2", 4'b0100, 1'b0, 1'b0, K_G, 2, 1'b0);
    rep(2, "er_green2_min", 4'b0000, 1'b0, 1'b0, K_G, 2, 1'b0);
    rep(2, "er_yel2", 4'b0000, 1'b0, 1'b0, K_Y, 2, 1'b0);
    vec("er_ar2", 4'b0000, 1'b0, 1'b0, K_AR, 2, 1'b0);
    vec("er_back0", 4'b0000, 1'b0, 1'b0, K_G, 0, 1'b1);

    // flash mid-yellow, blink 3 on / 3 off, exit via all-red to phase 0
    rep(3, "fl_main", 4'b0010, 1'b0, 1'b0, K_G, 0, 1'b0);
    vec("fl_yel", 4'b0010, 1'b0, 1'b0, K_Y, 0, 1'b0);
    rep(3, "fl_on1", 4'b0010, 1'b1, 1'b0, K_FON, 0, 1'b0);
    rep(3, "fl_off", 4'b0010, 1'b1, 1'b0, K_FOFF, 0, 1'b0);
    rep(2, "fl_on2", 4'b0010, 1'b1, 1'b0, K_FON, 0, 1'b0);
    vec("fl_exit_ar", 4'b0010, 1'b0, 1'b0, K_AR, 0, 1'b0);
    vec("fl_exit_main", 4'b0010, 1'b0, 1'b0, K_G, 0, 1'b1);
    rep(3, "fl_main_after", 4'b0000, 1'b0, 1'b0, K_G, 0, 1'b0);

    // reset during side green and during flash
    rep(2, "rs_yel0", 4'b0010, 1'b0, 1'b0, K_Y, 0, 1'b0);
    vec("rs_ar0", 4'b0010, 1'b0, 1'b0, K_AR, 0, 1'b0);
    vec("rs_start1", 4'b0010, 1'b0, 1'b0, K_G, 1, 1'b1);
    vec("rs_green1", 4'b0010, 1'b0, 1'b0, K_G, 1, 1'b0);
    vec("rs_reset_side", 4'b0010, 1'b0, 1'b1, K_G, 0, 1'b0);
    vec("rs_flash_on", 4'b0000, 1'b1, 1'b0, K_FON, 0, 1'b0);
    vec("rs_reset_flash", 4'b0000, 1'b1, 1'b1, K_G, 0, 1'b0);
    vec("rs_no_start", 4'b0000, 1'b0, 1'b0, K_G, 0, 1'b0);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never checked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule
